// File: rtl/load_store_unit.sv
// Word-wide load/store unit: decodes a 16-bit address space into an 8 KiB data
// memory, output peripheral registers and pass-through input ports.
module load_store_unit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_lsu_wren,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [31:0] o_io_lcd,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7
);

    logic [15:0] addr;
    logic        unused_addr_hi;

    assign addr           = i_lsu_addr[15:0];
    assign unused_addr_hi = ^i_lsu_addr[31:16];

    // Decoder
    logic sel_dmem, sel_ledr, sel_ledg, sel_hex, sel_lcd, sel_sw, sel_btn;

    assign sel_dmem = (addr[15:13] == 3'b001);
    assign sel_ledr = (addr[15:4] == 12'h700);
    assign sel_ledg = (addr[15:4] == 12'h701);
    assign sel_hex  = (addr[15:4] == 12'h702);
    assign sel_lcd  = (addr[15:4] == 12'h703);
    assign sel_sw   = (addr[15:4] == 12'h780);
    assign sel_btn  = (addr[15:4] == 12'h781);

    logic [10:0] dmem_idx;
    logic [2:0]  hex_idx;

    assign dmem_idx = addr[12:2];
    assign hex_idx  = addr[2:0];

    // Per-target write enables
    logic       we_dmem, we_ledr, we_ledg, we_lcd;
    logic [7:0] we_hex;

    always_comb begin
        we_dmem = i_lsu_wren && sel_dmem;
        we_ledr = i_lsu_wren && sel_ledr;
        we_ledg = i_lsu_wren && sel_ledg;
        we_lcd  = i_lsu_wren && sel_lcd;
        we_hex  = '0;
        if (i_lsu_wren && sel_hex) begin
            we_hex[hex_idx] = 1'b1;
        end
    end

    // DMEM has no reset; the explicit i_rst gate keeps stores blocked during reset.
    logic [31:0] dmem_q [2048];

    always_ff @(posedge i_clk) begin
        if (i_rst && we_dmem) begin
            dmem_q[dmem_idx] <= i_st_data;
        end
    end

    // Output register bank
    logic [31:0] ledr_q, ledr_d;
    logic [31:0] ledg_q, ledg_d;
    logic [31:0] lcd_q,  lcd_d;
    logic [6:0]  hex_q [8];
    logic [6:0]  hex_d [8];

    always_comb begin
        ledr_d = we_ledr ? i_st_data : ledr_q;
        ledg_d = we_ledg ? i_st_data : ledg_q;
        lcd_d  = we_lcd  ? i_st_data : lcd_q;
        for (int i = 0; i < 8; i++) begin
            hex_d[i] = we_hex[i] ? i_st_data[6:0] : hex_q[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ledr_q <= '0;
            ledg_q <= '0;
            lcd_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                hex_q[i] <= '0;
            end
        end else begin
            ledr_q <= ledr_d;
            ledg_q <= ledg_d;
            lcd_q  <= lcd_d;
            for (int i = 0; i < 8; i++) begin
                hex_q[i] <= hex_d[i];
            end
        end
    end

    // Load mux; unmapped addresses read as zero.
    always_comb begin
        o_ld_data = '0;
        if (sel_dmem) begin
            o_ld_data = dmem_q[dmem_idx];
        end else if (sel_ledr) begin
            o_ld_data = ledr_q;
        end else if (sel_ledg) begin
            o_ld_data = ledg_q;
        end else if (sel_hex) begin
            o_ld_data = {25'b0, hex_q[hex_idx]};
        end else if (sel_lcd) begin
            o_ld_data = lcd_q;
        end else if (sel_sw) begin
            o_ld_data = i_io_sw;
        end else if (sel_btn) begin
            o_ld_data = {28'b0, i_io_btn};
        end
    end

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;
    assign o_io_hex0 = hex_q[0];
    assign o_io_hex1 = hex_q[1];
    assign o_io_hex2 = hex_q[2];
    assign o_io_hex3 = hex_q[3];
    assign o_io_hex4 = hex_q[4];
    assign o_io_hex5 = hex_q[5];
    assign o_io_hex6 = hex_q[6];
    assign o_io_hex7 = hex_q[7];

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: memory map, register
// isolation, input pass-through and asynchronous reset behaviour.
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_lsu_wren = 1'b0;
    logic [31:0] i_lsu_addr = '0;
    logic [31:0] i_st_data = '0;
    logic [31:0] i_io_sw = '0;
    logic [3:0]  i_io_btn = '0;
    logic [31:0] o_ld_data, o_io_ledr, o_io_ledg, o_io_lcd;
    logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
    logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;

    int errors = 0;
    int checks = 0;

    load_store_unit dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_lsu_wren (i_lsu_wren),
        .i_lsu_addr (i_lsu_addr),
        .i_st_data  (i_st_data),
        .i_io_sw    (i_io_sw),
        .i_io_btn   (i_io_btn),
        .o_ld_data  (o_ld_data),
        .o_io_ledr  (o_io_ledr),
        .o_io_ledg  (o_io_ledg),
        .o_io_lcd   (o_io_lcd),
        .o_io_hex0  (o_io_hex0),
        .o_io_hex1  (o_io_hex1),
        .o_io_hex2  (o_io_hex2),
        .o_io_hex3  (o_io_hex3),
        .o_io_hex4  (o_io_hex4),
        .o_io_hex5  (o_io_hex5),
        .o_io_hex6  (o_io_hex6),
        .o_io_hex7  (o_io_hex7)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        @(negedge i_clk);
        i_lsu_addr = addr;
        i_st_data  = data;
        i_lsu_wren = 1'b1;
        @(posedge i_clk);
        #1;
        i_lsu_wren = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr);
        i_lsu_addr = addr;
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_ledr", o_io_ledr, 32'h0);
        check("rst_ledg", o_io_ledg, 32'h0);
        check("rst_lcd",  o_io_lcd,  32'h0);
        check("rst_hex0", {25'b0, o_io_hex0}, 32'h0);
        check("rst_hex7", {25'b0, o_io_hex7}, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b1;

        // DMEM write/readback
        store(32'h0000_2A14, 32'h1111_2222);
        store(32'h0000_2A10, 32'hDEAD_BEEF);
        load(32'h0000_2A10);  check("dmem_2a10", o_ld_data, 32'hDEAD_BEEF);
        load(32'h0000_2A13);  check("dmem_2a13", o_ld_data, 32'hDEAD_BEEF);
        load(32'h0000_2A14);  check("dmem_2a14", o_ld_data, 32'h1111_2222);
        load(32'hFFFF_2A10);  check("dmem_hi_ign", o_ld_data, 32'hDEAD_BEEF);

        // LEDR: old value until the edge, new value after it
        @(negedge i_clk);
        i_lsu_addr = 32'h0000_7000;
        i_st_data  = 32'h1234_5678;
        i_lsu_wren = 1'b1;
        #1;
        check("ledr_pre_edge", o_ld_data, 32'h0);
        @(posedge i_clk);
        #1;
        i_lsu_wren = 1'b0;
        check("ledr_port", o_io_ledr, 32'h1234_5678);
        check("ledr_load", o_ld_data, 32'h1234_5678);

        store(32'h0000_7010, 32'hA5A5_A5A5);
        check("ledg_port", o_io_ledg, 32'hA5A5_A5A5);
        check("ledr_keep", o_io_ledr, 32'h1234_5678);
        load(32'h0000_7010);  check("ledg_load", o_ld_data, 32'hA5A5_A5A5);

        // HEX
        store(32'h0000_7027, 32'hFFFF_FF7F);
        check("hex7", {25'b0, o_io_hex7}, 32'h7F);
        check("hex0_keep", {25'b0, o_io_hex0}, 32'h0);
        check("hex6_keep", {25'b0, o_io_hex6}, 32'h0);
        store(32'h0000_7020, 32'h0000_0040);
        check("hex0", {25'b0, o_io_hex0}, 32'h40);
        check("hex7_keep", {25'b0, o_io_hex7}, 32'h7F);
        load(32'h0000_7027);  check("hex7_load", o_ld_data, 32'h0000_007F);
        load(32'h0000_702F);  check("hex7_a3_ign", o_ld_data, 32'h0000_007F);
        store(32'h0000_702B, 32'h0000_0015);
        check("hex3_a3_ign", {25'b0, o_io_hex3}, 32'h15);

        // LCD and inputs
        store(32'h0000_7030, 32'h8000_0041);
        check("lcd_port", o_io_lcd, 32'h8000_0041);
        i_io_sw = 32'h0F0F_1234;
        store(32'h0000_7800, 32'h0000_0055);
        load(32'h0000_7800);  check("sw_load", o_ld_data, 32'h0F0F_1234);
        check("sw_ledr_keep", o_io_ledr, 32'h1234_5678);
        check("sw_lcd_keep",  o_io_lcd,  32'h8000_0041);
        check("sw_ledg_keep", o_io_ledg, 32'hA5A5_A5A5);
        i_io_sw = 32'hCAFE_0001;
        #1;
        check("sw_passthru", o_ld_data, 32'hCAFE_0001);
        i_io_btn = 4'b1010;
        load(32'h0000_7811);  check("btn_load", o_ld_data, 32'h0000_000A);

        // Unmapped
        store(32'h0000_5000, 32'hFFFF_FFFF);
        load(32'h0000_5000);  check("unmap_load", o_ld_data, 32'h0);
        check("unmap_ledr", o_io_ledr, 32'h1234_5678);
        check("unmap_ledg", o_io_ledg, 32'hA5A5_A5A5);
        check("unmap_lcd",  o_io_lcd,  32'h8000_0041);
        load(32'h0000_2A10);  check("unmap_dmem", o_ld_data, 32'hDEAD_BEEF);

        // Asynchronous reset between edges
        @(negedge i_clk);
        #2;
        i_rst = 1'b0;
        #1;
        check("arst_ledr", o_io_ledr, 32'h0);
        check("arst_ledg", o_io_ledg, 32'h0);
        check("arst_lcd",  o_io_lcd,  32'h0);
        check("arst_hex0", {25'b0, o_io_hex0}, 32'h0);
        check("arst_hex7", {25'b0, o_io_hex7}, 32'h0);

        // Stores ignored during reset
        store(32'h0000_7000, 32'h9999_9999);
        check("rst_st_ledr", o_io_ledr, 32'h0);
        store(32'h0000_2A10, 32'h0000_0099);
        load(32'h0000_2A10);  check("rst_st_dmem", o_ld_data, 32'hDEAD_BEEF);

        // First edge after release accepts a store
        @(negedge i_clk);
        i_rst = 1'b1;
        store(32'h0000_7000, 32'hCAFE_F00D);
        check("post_rst_ledr", o_io_ledr, 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Word-wide load/store unit between the CPU datapath and its memory-mapped resources. It decodes a 16-bit address space into an 8 KiB data memory, output peripheral registers and input peripheral ports. Stores are synchronous and loads are combinational. The block sits in the MEM stage of the single-cycle core.

## Interface
- Parameters: none. The memory map and DMEM size are fixed.
- i_clk  in  1  system clock; all state updates on its rising edge
- i_rst  in  1  reset; asynchronous, active-low
- i_lsu_wren  in  1  store enable; 1 = write i_st_data at i_lsu_addr on the next rising edge
- i_lsu_addr  in  32  byte address; bits [31:16] ignored
- i_st_data  in  32  store data
- i_io_sw  in  32  switch inputs
- i_io_btn  in  4  push-button inputs
- o_ld_data  out  32  load data for i_lsu_addr (combinational)
- o_io_ledr  out  32  red LED register
- o_io_ledg  out  32  green LED register
- o_io_lcd  out  32  LCD control/data register
- o_io_hex0 … o_io_hex7  out  7 each  seven-segment registers

## Operation
- Address decode uses A = i_lsu_addr[15:0].
- DMEM: A[15:13]=3'b001 (0x2000–0x3FFF).
  - 2048 × 32-bit words, indexed by A[12:2]; A[1:0] ignored.
  - Word-only access: no byte or halfword lanes.
- LEDR: A[15:4]=0x700 (0x7000–0x700F). 32-bit register.
- LEDG: A[15:4]=0x701. 32-bit register.
- HEX: A[15:4]=0x702.
  - A[2:0] selects o_io_hex0..7; 0x7020→hex0 … 0x7027→hex7. A[3] ignored.
  - A store writes i_st_data[6:0] to the selected register.
  - A load returns {25'b0, hexN}.
- LCD: A[15:4]=0x703. 32-bit register.
- SW: A[15:4]=0x780. Loads return i_io_sw. Stores are ignored.
- BTN: A[15:4]=0x781 (0x7810–0x781F). Loads return {28'b0, i_io_btn}. Stores are ignored.
- Unmapped addresses: loads return 32'h0; stores have no effect.
- Every output register drives its port directly.
- A store updates exactly one target. All other state is unchanged.
- Implementation shape: decoder, combinational load mux, DMEM array, and a register bank with per-register write enables.

## Timing
- Store: when i_lsu_wren=1 and i_rst=1 at a rising edge of i_clk, the target is updated at that edge. Zero wait states; there is no handshake.
- Load: o_ld_data is combinational from i_lsu_addr and the current contents.
  - Same-cycle load after a store shows the old value until the edge and the new value after it.
  - Input ports (SW/BTN) are passed through without registration: zero latency.
- Holding i_lsu_wren=1 across several edges rewrites the same value each edge. This has no additional effect.
- Reset: when i_rst=0, LEDR, LEDG, LCD and hex0..7 clear to 0 immediately, independent of the clock.
  - Stores are blocked while i_rst=0.
  - DMEM contents are not reset; they are undefined until written.
- Reset asserted mid-store: the store is lost and the register reads 0.
- Reset release: the first store is accepted at the first rising edge with i_rst=1.

## Test plan
- DMEM write/readback:
  - Store 0xDEADBEEF at 0x2A10.
  - After the edge, o_ld_data=0xDEADBEEF at 0x2A10 and also at 0x2A13 (alignment bits ignored).
  - 0x2A14 is unaffected.
- LED registers:
  - Store 0x12345678 at 0x7000 → o_io_ledr=0x12345678; loads from 0x7000 return it.
  - Store 0xA5A5A5A5 at 0x7010 → o_io_ledg=0xA5A5A5A5; LEDR is unchanged.
- HEX byte addressing:
  - Store 0xFFFFFF7F at 0x7027 → o_io_hex7=7'h7F; hex0..6 unchanged.
  - Store 0x00000040 at 0x7020 → o_io_hex0=7'h40.
  - Load 0x7027 returns 0x0000007F.
- LCD and inputs:
  - Store 0x80000041 at 0x7030 → o_io_lcd=0x80000041.
  - i_io_sw=0x0F0F1234 with a store of 0x55 at 0x7800 → load returns 0x0F0F1234; no output changes.
  - i_io_btn=4'b1010, read 0x7811 → 0x0000000A.
- Unmapped: store to 0x5000 changes nothing; load from 0x5000 returns 0.
- Reset:
  - With LEDR=0x12345678, drive i_rst=0 between edges → all output registers read 0 immediately.
  - A store with wren=1 during reset is ignored.
